muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit with HI/LO result registers.
//  Sits beside the ALU in the execute stage and serves mult/multu/div/divu and mthi/mtlo.
//  busy drives the hazard unit's stall for decode-stage mfhi/mflo and new muldiv ops.
//  flush drives the hazard unit's abort.
//  Successor to the single-cycle highlow path: width-generic, multi-cycle, abortable.
// PARAMETERS
//  WIDTH     32  operand width; HI and LO are WIDTH bits each
//  FAST_MUL  0   1: mult/multu skip RUN (one-cycle array multiply); 0: shift-add, WIDTH cycles
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      synchronous, active-high
//  start     in   1      launch op; sampled only in IDLE
//  op        in   2      00 mult, 01 multu, 10 div, 11 divu
//  srca      in   WIDTH  multiplicand / dividend
//  srcb      in   WIDTH  multiplier / divisor
//  flush     in   1      abort in-flight op
//  hilo_we   in   1      mthi/mtlo write enable
//  hilo_sel  in   1      0 = write LO, 1 = write HI
//  hilo_wd   in   WIDTH  mthi/mtlo data
//  busy      out  1      state != IDLE
//  done      out  1      one-cycle pulse: HI/LO just updated by an op
//  hi        out  WIDTH  HI register (product high half / remainder)
//  lo        out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; hi=0; lo=0; busy=0; done=0; counter=0.
//   Reset overrides everything, including mid-operation.
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//  IDLE, start=1, flush=0 at edge E0:
//   - latch |srca|, |srcb| (signed ops use two's-complement magnitude; unsigned ops pass through)
//   - latch sign flags and op; counter=WIDTH
//   - next state RUN (FIX directly for mult/multu when FAST_MUL=1)
//  RUN: one bit per edge.
//   - Multiply: shift-add into 2*WIDTH accumulator.
//   - Divide: restoring shift-subtract producing quotient and remainder.
//   - counter decrements; at counter==1 next state FIX.
//  FIX, one edge:
//   - sign correction applied; hi/lo written; done=1 for the following cycle; state IDLE.
//  Latency (FAST_MUL=0):
//   - start sampled at E0; hi/lo and done valid after edge E(WIDTH+1).
//   - busy=1 for WIDTH+1 cycles.
//  Latency (FAST_MUL=1, mult/multu): valid after E1; busy=1 for 1 cycle.
//  Signs:
//   - product negated if sa^sb
//   - quotient negated if sa^sb
//   - remainder takes sign of sa
//  Divide by zero: lo={WIDTH{1'b1}}, hi=srca (raw); same latency; no exception.
//  Signed MIN/-1: lo=MIN, hi=0. Falls out of the magnitude path; no special case.
//  start while busy: ignored, no effect on in-flight op.
//  hilo_we:
//   - honoured only in IDLE; ignored while busy (pipeline stalls, so never expected).
//   - hilo_we and start in the same IDLE cycle: write applies at E0; op result overwrites at FIX.
//  flush:
//   - any state -> IDLE next edge; hi/lo unchanged; no done pulse.
//   - flush with start in the same cycle: flush wins, start dropped.
//   - flush in FIX cycle: FIX completes is NOT allowed; flush wins, hi/lo unchanged.
//  Outputs are registered; no combinational path from start to busy/done.
// TESTING (WIDTH=32, FAST_MUL=0 unless noted)
//  multu 3 x 5 at E0 -> done at E33, lo=0x0000000F, hi=0; busy high exactly 33 cycles.
//  mult -2 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. With FAST_MUL=1: same values, done after E1.
//  div -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  div 0x80000000 / -1 -> lo=0x80000000, hi=0.
//  divu 9 / 0 -> lo=0xFFFFFFFF, hi=9.
//  multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  Abort/override sequences:
//   - start div, flush at cycle 10 -> IDLE next edge, hi/lo keep prior values, no done.
//   - start a second op at cycle 5 -> ignored; first result intact.
//   - reset at cycle 20 -> hi=lo=0, busy=0.
//  mtlo 0x1234 while IDLE -> lo=0x1234 next cycle; mthi while busy -> hi unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with HI/LO result registers.
// mult/multu/div/divu run over WIDTH cycles (or one cycle for multiplies when
// FAST_MUL=1). A final FIX cycle applies the sign correction and writes HI/LO.
// mthi/mtlo write HI/LO directly while the unit is idle.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]        counter;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   acc;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     a_raw;
    logic                 sa, sb, is_div, div_zero;

    // Operand conditioning at launch.
    logic                 in_signed, a_neg, b_neg, launch;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   fast_prod;

    // One iteration of the datapath.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial, div_diff;
    logic [2*WIDTH-1:0]   acc_step;

    // Sign-corrected results for FIX.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;
    logic [WIDTH-1:0]     hi_res, lo_res;

    assign busy = (state != S_IDLE);

    // Operand magnitudes and launch qualification.
    always_comb begin
        in_signed = ~op[0];
        a_neg     = in_signed & srca[WIDTH-1];
        b_neg     = in_signed & srcb[WIDTH-1];
        a_mag     = a_neg ? (~srca + 1'b1) : srca;
        b_mag     = b_neg ? (~srcb + 1'b1) : srcb;
        fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
        launch    = (state == S_IDLE) && start && !flush;
    end

    // Single shift-add or restoring shift-subtract step.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH])
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction; divide by zero returns the raw dividend and all-ones.
    always_comb begin
        prod_fix = (sa ^ sb) ? (~acc + 1'b1) : acc;
        quot_fix = (sa ^ sb) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = sa ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            hi_res = a_raw;
            lo_res = {WIDTH{1'b1}};
        end else begin
            hi_res = rem_fix;
            lo_res = quot_fix;
        end
    end

    // Next-state logic; flush aborts from any state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (launch) state_next = (FAST_MUL && !op[1]) ? S_FIX : S_RUN;
            S_RUN:  if (counter == CW'(1)) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    // State register, operand latches, iteration datapath and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            counter  <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hilo_we) begin
                        if (hilo_sel) hi <= hilo_wd;
                        else          lo <= hilo_wd;
                    end
                    if (launch) begin
                        sa       <= a_neg;
                        sb       <= b_neg;
                        is_div   <= op[1];
                        div_zero <= (srcb == '0);
                        a_raw    <= srca;
                        counter  <= CW'(WIDTH);
                        if (op[1]) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= FAST_MUL ? fast_prod : {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                S_RUN: begin
                    counter <= counter - 1'b1;
                    acc     <= acc_step;
                end
                S_FIX: begin
                    if (!flush) begin
                        hi   <= hi_res;
                        lo   <= lo_res;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
